// File: rtl/mmm_nlp_mult_seq.sv
// -----------------------------------------------------------------------------
// mmm_nlp_mult_seq
//   Digit-serial exact multiplier for the Montgomery datapath:
//     o_res = i_a * i_b + i_carry            (default build)
//     o_res = i_a * i_b + i_c + i_carry      (MMM_NLP_MULT_ACC_EN defined)
//   i_b is consumed one BW-bit digit per cycle against the full i_a, so one
//   operation takes NDIG = ceil(IDW/BW) MUL cycles. The result is never
//   truncated: ODW >= 2*IDW+1 holds the largest possible sum.
//
// Optional feature macro: MMM_NLP_MULT_ACC_EN (adds addend port i_c).
//
// Ports:
//   i_clk    in   1    clock, all state on rising edge
//   i_rst    in   1    asynchronous active-high reset
//   i_valid  in   1    operand request
//   o_ready  out  1    block can accept operands (IDLE)
//   i_a      in   IDW  multiplicand
//   i_b      in   IDW  multiplier
//   i_c      in   IDW  addend (MMM_NLP_MULT_ACC_EN only)
//   i_carry  in   1    carry-in added to the product
//   o_valid  out  1    o_res holds a new result (DONE)
//   i_ready  in   1    consumer accepts the result
//   o_res    out  ODW  result, stable until the next DONE entry
//   o_busy   out  1    state is MUL
// -----------------------------------------------------------------------------
module mmm_nlp_mult_seq #(
    parameter int IDW = 90,
    parameter int BW  = 16,
    parameter int ODW = 2*IDW+1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [IDW-1:0] i_a,
    input  logic [IDW-1:0] i_b,
`ifdef MMM_NLP_MULT_ACC_EN
    input  logic [IDW-1:0] i_c,
`endif
    input  logic           i_carry,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [ODW-1:0] o_res,
    output logic           o_busy
);

    localparam int NDIG = (IDW + BW - 1) / BW;
    localparam int BPW  = NDIG * BW;          // i_b zero-extended width
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PPW  = IDW + BW;           // partial product width
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [IDW-1:0] a_q,     a_d;
    logic [BPW-1:0] b_q,     b_d;
    logic [ODW-1:0] acc_q,   acc_d;
    logic [ODW-1:0] res_q,   res_d;
    logic           valid_q, valid_d;

    logic [PPW-1:0] pp;
    logic [ODW-1:0] pp_sh;
    logic [ODW-1:0] sum;
    int unsigned    shamt;
    logic [ODW-1:0] acc_init;

    // b_q is shifted right one digit per MUL cycle, so the active digit is
    // always the low BW bits; this equals b_r[cnt*BW +: BW] of the original
    // operand without a wide variable part-select mux.
    always_comb begin
        shamt = int'(cnt_q) * BW;
        pp    = PPW'(a_q) * PPW'(b_q[BW-1:0]);
        // Bits shifted past ODW are provably zero (top digit is zero-extended).
        pp_sh = ODW'(pp) << shamt;
        sum   = acc_q + pp_sh;
    end

    always_comb begin
        acc_init = ODW'(i_carry);
`ifdef MMM_NLP_MULT_ACC_EN
        acc_init = acc_init + ODW'(i_c);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = BPW'(i_b);
                    acc_d   = acc_init;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = sum;
                b_d   = b_q >> BW;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    res_d   = sum;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    // Ready is withheld while reset is asserted so nothing looks acceptable
    // until the block is actually running.
    assign o_ready = (state_q == S_IDLE) && !i_rst;
    assign o_busy  = (state_q == S_MUL);
    assign o_valid = valid_q;
    assign o_res   = res_q;

endmodule
